// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Sequential instruction fetch front end. It issues word-aligned fetch
//   requests to an in-order memory and buffers the returned words together
//   with their addresses. It hands the oldest buffered word to the decoder.
//   A redirect flushes the buffer and restarts fetch at a new target. Any
//   responses still in flight from the old path are silently dropped. A
//   decoder error on the head word stops the unit until reset.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  buffer entries, which is also the outstanding-request limit
//              (legal values 2 or 4)
//
// Ports:
//   Clock                     single clock, rising-edge
//   ResetN                    synchronous active-low reset
//   MemReqValid/Ready         fetch request handshake
//   MemReqAddress             word-aligned fetch address
//   MemRespValid/Data         in-order response, one per accepted request
//   InstructionValid/Ready    buffer head handshake toward the decoder
//   Instruction               buffer head word
//   InstructionPC             address of the head word
//   RedirectValid/PC          branch/jump redirect; PC bits [1:0] ignored
//   InvalidInstructionSignal  decoder error for the current head
//   Halted                    fetch stopped after an invalid instruction
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemReqAddress,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData,
  output logic        InstructionValid,
  input  logic        InstructionReady,
  output logic [31:0] Instruction,
  output logic [31:0] InstructionPC,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  input  logic        InvalidInstructionSignal,
  output logic        Halted
);

  // Pointer width covers the two legal depths (2 -> 1 bit, 4 -> 2 bits).
  // Counters need one more bit so they can hold the full depth value.
  localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [31:0]      r_fetchPc;
  logic [31:0]      r_respPc;
  logic [31:0]      r_bufWord [BUF_DEPTH];
  logic [31:0]      r_bufPc   [BUF_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_dropCount;

  logic             w_run;
  logic             w_redirect;
  logic [31:0]      w_redirTarget;
  logic [CNT_W:0]   w_creditSum;
  logic             w_credit;
  logic             w_memReqValid;
  logic             w_reqFire;
  logic             w_instValid;
  logic             w_pop;
  logic             w_dropHit;
  logic             w_push;
  logic [CNT_W-1:0] w_outAfterResp;
  logic [CNT_W-1:0] w_outNext;
  logic [CNT_W-1:0] w_countNext;
  logic             w_haltTrig;

  // Control decode.
  // A redirect only matters while running; in HALT it is ignored.
  // Requests are throttled so that every word already in flight is
  // guaranteed a buffer slot. This is why the buffer never overflows.
  // Dropped responses still count against this limit, so a redirect
  // cannot flood the memory with requests.
  always_comb begin
    w_run          = (r_state == ST_RUN);
    w_redirect     = RedirectValid & w_run;
    w_redirTarget  = RedirectPC & 32'hFFFF_FFFC;
    w_creditSum    = {1'b0, r_outstanding} + {1'b0, r_count};
    w_credit       = (w_creditSum < DEPTH_L);
    w_memReqValid  = ResetN & w_run & ~RedirectValid & w_credit;
    w_reqFire      = w_memReqValid & MemReqReady;
    w_instValid    = ResetN & w_run & (r_count != '0);
    w_pop          = w_instValid & InstructionReady;
    w_dropHit      = MemRespValid & (r_dropCount != '0);
    w_push         = MemRespValid & w_run & ~w_dropHit;
    w_haltTrig     = w_run & InvalidInstructionSignal & w_instValid;
    w_outAfterResp = MemRespValid ? (r_outstanding - CNT_W'(1)) : r_outstanding;
  end

  // Next outstanding count. A handshake and a response in the same cycle
  // cancel out.
  always_comb begin
    w_outNext = r_outstanding;
    case ({w_reqFire, MemRespValid})
      2'b10:   w_outNext = r_outstanding + CNT_W'(1);
      2'b01:   w_outNext = r_outstanding - CNT_W'(1);
      default: w_outNext = r_outstanding;
    endcase
  end

  // Next buffer occupancy when there is no flush.
  // A push and a pop together leave the occupancy unchanged. This also
  // holds on a full buffer.
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + CNT_W'(1);
      2'b01:   w_countNext = r_count - CNT_W'(1);
      default: w_countNext = r_count;
    endcase
  end

  // State register for the RUN/HALT machine.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. HALT is sticky: only reset leaves it.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_RUN:  if (w_haltTrig) w_stateNext = ST_HALT;
      ST_HALT: w_stateNext = ST_HALT;
      default: w_stateNext = ST_RUN;
    endcase
  end

  // Fetch and response bookkeeping.
  // r_respPc is the address that belongs to the next response that will be
  // kept. Responses are in order, so it only moves on kept words.
  // A redirect restarts it at the target, and the drop counter skips
  // everything still in flight from the old path.
  // The drop counter is loaded with the outstanding count after this
  // cycle's response. A response arriving in the same cycle as the
  // redirect is therefore discarded once, not twice.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_outstanding <= '0;
      r_dropCount   <= '0;
    end else begin
      r_outstanding <= w_outNext;
      if (w_redirect) begin
        r_fetchPc   <= w_redirTarget;
        r_respPc    <= w_redirTarget;
        r_dropCount <= w_outAfterResp;
      end else begin
        if (w_reqFire) begin
          r_fetchPc <= r_fetchPc + 32'd4;
        end
        if (w_push) begin
          r_respPc <= r_respPc + 32'd4;
        end
        if (w_dropHit) begin
          r_dropCount <= r_dropCount - CNT_W'(1);
        end
      end
    end
  end

  // Buffer pointers and occupancy. A flush takes priority over a push or a
  // pop in the same cycle.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
    end
  end

  // Buffer storage. No reset is needed: an entry is only visible once it
  // has been written and counted.
  always_ff @(posedge Clock) begin
    if (ResetN && w_push && !w_redirect) begin
      r_bufWord[r_wrPtr] <= MemRespData;
      r_bufPc[r_wrPtr]   <= r_respPc;
    end
  end

  // Outputs. They are qualified with ResetN so that they read as idle
  // while reset is held, even before the first reset edge.
  always_comb begin
    MemReqValid      = w_memReqValid;
    MemReqAddress    = r_fetchPc;
    InstructionValid = w_instValid;
    Instruction      = w_instValid ? r_bufWord[r_rdPtr] : 32'h0;
    InstructionPC    = w_instValid ? r_bufPc[r_rdPtr]   : 32'h0;
    Halted           = ResetN & (r_state == ST_HALT);
  end

endmodule
